ex_mem_pipe_reg: RTL

Parametrised EX/MEM pipeline register for the MIPS32 datapath. It carries the WB/M control fields, the zero flag, the ALU result, the store data and the write addresses from EX to MEM. Unlike a plain register it adds a valid/ready handshake, an optional skid entry, flush (bubble insertion), async reset and a registered branch-taken output. It sits between the ALU stage and the data memory and is driven by the hazard unit.

---
 rtl/ex_mem_pipe_reg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register for the MIPS32 datapath with a valid/ready handshake,
// an optional skid entry, flush, gated control outputs and a registered branch-taken flag.
module ex_mem_pipe_reg #(
   parameter int SIZE       = 32,
   parameter int ADDR_SIZE  = 5,
   parameter int S_WB       = 2,
   parameter int S_M        = 3,
   parameter int BRANCH_BIT = 0,
   parameter int SKID       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [S_WB-1:0]      WB,
   input  logic [S_M-1:0]       M,
   input  logic                 zero_in,
   input  logic [SIZE-1:0]      data_in,
   input  logic [SIZE-1:0]      data_in2,
   input  logic [SIZE-1:0]      AWriteMem_in,
   input  logic [ADDR_SIZE-1:0] AWriteReg_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [S_WB-1:0]      WB_out,
   output logic [S_M-1:0]       M_out,
   output logic                 zero_out,
   output logic [SIZE-1:0]      data_out,
   output logic [SIZE-1:0]      data_out2,
   output logic [SIZE-1:0]      AWriteMem,
   output logic [ADDR_SIZE-1:0] AWriteReg,
   output logic                 branch_taken,
   output logic                 full
);

   localparam int PW      = S_WB + S_M + 1 + 3 * SIZE + ADDR_SIZE;
   localparam int AWM_LSB = ADDR_SIZE;
   localparam int D2_LSB  = AWM_LSB + SIZE;
   localparam int D_LSB   = D2_LSB + SIZE;
   localparam int Z_POS   = D_LSB + SIZE;
   localparam int M_LSB   = Z_POS + 1;
   localparam int WB_LSB  = M_LSB + S_M;

   logic [PW-1:0] in_payload;
   logic [PW-1:0] main_q;
   logic [PW-1:0] main_n;
   logic          main_valid;
   logic          main_valid_n;
   logic          skid_valid;
   logic          branch_q;
   logic          in_xfer;
   logic          out_xfer;

   assign in_payload = {WB, M, zero_in, data_in, data_in2, AWriteMem_in, AWriteReg_in};
   assign in_xfer    = in_valid & in_ready;
   assign out_xfer   = main_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic [PW-1:0] skid_q;
         logic [PW-1:0] skid_n;
         logic          skid_valid_n;
         logic          ready_q;

         // Main refills from the skid first so ordering stays FIFO; the skid only
         // catches an input that arrives while main is stalled.
         always_comb begin
            main_n       = main_q;
            main_valid_n = main_valid;
            skid_n       = skid_q;
            skid_valid_n = skid_valid;
            if (flush) begin
               main_valid_n = 1'b0;
               skid_valid_n = 1'b0;
            end else if (!main_valid || out_xfer) begin
               if (skid_valid) begin
                  main_n       = skid_q;
                  main_valid_n = 1'b1;
                  skid_valid_n = in_xfer;
                  if (in_xfer) begin
                     skid_n = in_payload;
                  end
               end else begin
                  main_valid_n = in_xfer;
                  if (in_xfer) begin
                     main_n = in_payload;
                  end
               end
            end else if (in_xfer) begin
               skid_n       = in_payload;
               skid_valid_n = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skid_q     <= '0;
               skid_valid <= 1'b0;
               ready_q    <= 1'b1;
            end else begin
               skid_q     <= skid_n;
               skid_valid <= skid_valid_n;
               ready_q    <= ~skid_valid_n;
            end
         end

         assign in_ready = ready_q;
      end else begin : g_single
         always_comb begin
            main_n       = main_q;
            main_valid_n = main_valid;
            if (flush) begin
               main_valid_n = 1'b0;
            end else if (in_xfer) begin
               main_n       = in_payload;
               main_valid_n = 1'b1;
            end else if (out_xfer) begin
               main_valid_n = 1'b0;
            end
         end

         assign skid_valid = 1'b0;
         assign in_ready   = out_ready | ~main_valid;
      end
   endgenerate

   // Branch flag is computed from the next main entry so it leaves a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         main_valid <= 1'b0;
         branch_q   <= 1'b0;
      end else begin
         main_q     <= main_n;
         main_valid <= main_valid_n;
         branch_q   <= main_valid_n & main_n[M_LSB + BRANCH_BIT] & main_n[Z_POS];
      end
   end

   assign out_valid    = main_valid;
   assign WB_out       = main_valid ? main_q[WB_LSB +: S_WB] : '0;
   assign M_out        = main_valid ? main_q[M_LSB +: S_M] : '0;
   assign zero_out     = main_q[Z_POS];
   assign data_out     = main_q[D_LSB +: SIZE];
   assign data_out2    = main_q[D2_LSB +: SIZE];
   assign AWriteMem    = main_q[AWM_LSB +: SIZE];
   assign AWriteReg    = main_q[0 +: ADDR_SIZE];
   assign branch_taken = branch_q;
   assign full         = main_valid & skid_valid;

endmodule
